// File: rtl/stream_demux.sv
// One-to-N stream demultiplexer: each accepted beat is steered by in_sel into
// a per-channel 2-entry FIFO, and every channel drains to its own consumer.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [7:0]           drop_count
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e             occ_q  [N];
  occ_e             occ_d  [N];
  logic [WIDTH-1:0] head_q [N];
  logic [WIDTH-1:0] head_d [N];
  logic [WIDTH-1:0] tail_q [N];
  logic [WIDTH-1:0] tail_d [N];
  logic [7:0]       drop_q;
  logic [7:0]       drop_d;

  logic             in_range;
  logic             accept;
  logic [N-1:0]     push;
  logic [N-1:0]     pop;

  // in_ready looks only at registered occupancy, so out_ready never reaches it.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    in_range = 1'b0;
    in_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (in_sel == SELW'(i)) begin
        in_range = 1'b1;
        in_ready = (occ_q[i] != OCC_FULL);
      end
    end
  end

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    drop_d = drop_q;
    if (accept && !in_range && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    for (int i = 0; i < N; i++) begin
      push[i]   = accept && in_range && (in_sel == SELW'(i));
      occ_d[i]  = occ_q[i];
      head_d[i] = head_q[i];
      tail_d[i] = tail_q[i];
      unique case (occ_q[i])
        OCC_EMPTY: begin
          if (push[i]) begin
            head_d[i] = in_data;
            occ_d[i]  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          unique case ({push[i], pop[i]})
            2'b10: begin
              tail_d[i] = in_data;
              occ_d[i]  = OCC_FULL;
            end
            2'b01:   occ_d[i]  = OCC_EMPTY;
            // Simultaneous pop and push: the new beat replaces the head.
            2'b11:   head_d[i] = in_data;
            default: ;
          endcase
        end
        OCC_FULL: begin
          if (pop[i]) begin
            head_d[i] = tail_q[i];
            occ_d[i]  = OCC_ONE;
          end
        end
        default: occ_d[i] = OCC_EMPTY;
      endcase
    end
  end

  // NOTE: the storage words are reset too, because out_data must read zero
  // straight out of reset rather than whatever the flops powered up with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 8'd0;
      for (int i = 0; i < N; i++) begin
        occ_q[i]  <= OCC_EMPTY;
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      drop_q <= drop_d;
      for (int i = 0; i < N; i++) begin
        occ_q[i]  <= occ_d[i];
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign out_valid[g]                = (occ_q[g] != OCC_EMPTY);
    assign out_data[g*WIDTH +: WIDTH]  = head_q[g];
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed vector table, hand-written
// reset and drop sequences, then random traffic against a queue-based model.
module tb_stream_demux;
  localparam int WIDTH = 8;
  localparam int N     = 3;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   in_data;
  logic [SELW-1:0]    in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic [7:0]         drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  stream_demux #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] data;
    logic [2:0] ordy;
    logic       rdy;     // in_ready before the edge
    logic [2:0] ovalid;  // out_valid after the edge
    logic [23:0] odata;  // {ch2, ch1, ch0}, compared only where ovalid is set
    logic [7:0] drop;
  } vec_t;

  vec_t tbl [$];

  // Behavioural reference: one queue per channel plus a drop tally.
  logic [7:0] mq [N][$];
  int         mdrops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] sel, input logic [7:0] data,
                     input logic [2:0] ordy, input logic rdy, input logic [2:0] ovalid,
                     input logic [23:0] odata, input logic [7:0] drop);
    vec_t r;
    r.v = v; r.sel = sel; r.data = data; r.ordy = ordy; r.rdy = rdy;
    r.ovalid = ovalid; r.odata = odata; r.drop = drop;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] data,
                       input logic [2:0] ordy);
    in_valid  = v;
    in_sel    = sel;
    in_data   = data;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] chan(input int i);
    return out_data[i*WIDTH +: WIDTH];
  endfunction

  initial begin
    logic       ok;
    logic       hold;
    logic       exp_rdy;
    logic       acc;
    logic [7:0] exp_drop;

    rst = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_drop_count", 32'(drop_count), 32'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("reset_in_ready_sel%0d", s), 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;

    // v sel data ordy | rdy ovalid odata drop
    add(1'b1, 2'd0, 8'hA1, 3'b111, 1'b1, 3'b001, 24'h0000A1, 8'd0);
    add(1'b1, 2'd1, 8'hB2, 3'b111, 1'b1, 3'b010, 24'h00B200, 8'd0);
    add(1'b1, 2'd2, 8'hC3, 3'b111, 1'b1, 3'b100, 24'hC30000, 8'd0);
    add(1'b0, 2'd3, 8'h00, 3'b111, 1'b1, 3'b000, 24'h000000, 8'd0);
    add(1'b1, 2'd1, 8'h11, 3'b101, 1'b1, 3'b010, 24'h001100, 8'd0);
    add(1'b1, 2'd1, 8'h22, 3'b101, 1'b1, 3'b010, 24'h001100, 8'd0);
    add(1'b1, 2'd1, 8'h33, 3'b101, 1'b0, 3'b010, 24'h001100, 8'd0);
    add(1'b1, 2'd1, 8'h33, 3'b111, 1'b0, 3'b010, 24'h002200, 8'd0);
    add(1'b1, 2'd1, 8'h33, 3'b111, 1'b1, 3'b010, 24'h003300, 8'd0);
    add(1'b0, 2'd3, 8'h00, 3'b111, 1'b1, 3'b000, 24'h000000, 8'd0);
    add(1'b1, 2'd0, 8'h44, 3'b110, 1'b1, 3'b001, 24'h000044, 8'd0);
    add(1'b1, 2'd0, 8'h45, 3'b110, 1'b1, 3'b001, 24'h000044, 8'd0);
    add(1'b1, 2'd2, 8'h77, 3'b110, 1'b1, 3'b101, 24'h770044, 8'd0);
    add(1'b1, 2'd0, 8'h46, 3'b010, 1'b0, 3'b101, 24'h770044, 8'd0);
    add(1'b1, 2'd2, 8'h78, 3'b110, 1'b1, 3'b101, 24'h780044, 8'd0);
    add(1'b0, 2'd3, 8'h00, 3'b100, 1'b1, 3'b001, 24'h000044, 8'd0);
    add(1'b1, 2'd2, 8'h55, 3'b010, 1'b1, 3'b101, 24'h550044, 8'd0);
    add(1'b1, 2'd2, 8'h66, 3'b110, 1'b1, 3'b101, 24'h660044, 8'd0);
    add(1'b0, 2'd3, 8'h00, 3'b111, 1'b1, 3'b001, 24'h000045, 8'd0);
    add(1'b0, 2'd3, 8'h00, 3'b111, 1'b1, 3'b000, 24'h000000, 8'd0);
    add(1'b1, 2'd3, 8'h99, 3'b111, 1'b1, 3'b000, 24'h000000, 8'd1);

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].sel, tbl[k].data, tbl[k].ordy);
      #1;
      check($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].rdy));
      tick();
      check($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].ovalid));
      for (int i = 0; i < N; i++) begin
        if (tbl[k].ovalid[i]) begin
          check($sformatf("vec%0d_out_data%0d", k, i), 32'(chan(i)),
                32'(tbl[k].odata[i*8 +: 8]));
        end
      end
      check($sformatf("vec%0d_drop_count", k), 32'(drop_count), 32'(tbl[k].drop));
    end

    // Out-of-range flood: drop_count saturates at 255, nothing is ever presented.
    ok = 1'b1;
    for (int b = 1; b <= 300; b++) begin
      drive(1'b1, 2'd3, 8'(b), 3'b111);
      #1;
      if (in_ready !== 1'b1) ok = 1'b0;
      tick();
      if (out_valid !== 3'b000) ok = 1'b0;
      if (b == 254) check("drop_reaches_255", 32'(drop_count), 32'd255);
    end
    check("drop_flood_ready_no_valid", 32'(ok), 32'd1);
    check("drop_saturated", 32'(drop_count), 32'd255);

    // Asynchronous reset pulse between edges with channels 0 and 1 loaded.
    drive(1'b1, 2'd0, 8'h10, 3'b000);
    tick();
    drive(1'b1, 2'd1, 8'h20, 3'b000);
    tick();
    drive(1'b0, 2'd3, 8'h00, 3'b000);
    check("pre_reset_valid", 32'(out_valid), 32'b011);
    rst = 1'b1;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_drop", 32'(drop_count), 32'd0);
    check("async_reset_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    #1;
    drive(1'b1, 2'd0, 8'h5A, 3'b000);
    tick();
    check("post_reset_valid", 32'(out_valid), 32'b001);
    check("post_reset_data0", 32'(chan(0)), 32'h5A);

    // A beat presented across an edge with rst held high is not taken.
    rst = 1'b1;
    drive(1'b1, 2'd1, 8'h6B, 3'b000);
    tick();
    check("reset_edge_no_accept", 32'(out_valid), 32'd0);
    rst = 1'b0;

    // Random traffic against the queue model, holding a stalled beat stable.
    mdrops = 0;
    hold   = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 8'($urandom);
      end
      out_ready = 3'($urandom);
      #1;
      exp_rdy = (int'(in_sel) >= N) ? 1'b1 : (mq[in_sel].size() < 2);
      check($sformatf("rand%0d_in_ready", c), 32'(in_ready), 32'(exp_rdy));
      acc  = in_valid && exp_rdy;
      hold = in_valid && !exp_rdy;
      tick();
      for (int i = 0; i < N; i++) begin
        if (mq[i].size() > 0 && out_ready[i]) void'(mq[i].pop_front());
      end
      if (acc) begin
        if (int'(in_sel) < N) mq[in_sel].push_back(in_data);
        else                  mdrops++;
      end
      exp_drop = (mdrops > 255) ? 8'd255 : 8'(mdrops);
      for (int i = 0; i < N; i++) begin
        check($sformatf("rand%0d_valid%0d", c, i), 32'(out_valid[i]),
              32'(mq[i].size() > 0));
        if (mq[i].size() > 0) begin
          check($sformatf("rand%0d_data%0d", c, i), 32'(chan(i)), 32'(mq[i][0]));
        end
      end
      check($sformatf("rand%0d_drop", c), 32'(drop_count), 32'(exp_drop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Single-stream to N-channel demultiplexer with valid/ready handshakes on both sides. Each accepted input beat is routed by its select field into a per-channel 2-entry buffer, and each channel drains independently to its own consumer. It is the sequential counterpart of the select-driven mux: one source fans out to many sinks, with per-channel backpressure and no head-of-line coupling between channels. Beats whose select is out of range are consumed, discarded and counted.

## Interface
Parameters:
- WIDTH, 8, data bits per beat.
- N, 3, number of output channels (1..2^SELW).
- SELW, 2, width of the select field.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  input beat payload.
- in_sel  in  SELW  destination channel of the current beat.
- in_valid  in  1  source presents a beat.
- in_ready  out  1  block accepts the beat this cycle.
- out_data  out  N*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].
- out_valid  out  N  channel i holds a beat.
- out_ready  in  N  consumer i takes the head beat this cycle.
- drop_count  out  8  saturating count of out-of-range beats dropped.

## Operation
- Handshake on both sides: a transfer occurs on a rising edge where valid and ready are both high. The source must hold in_data and in_sel stable while in_valid is high and in_ready is low.
- Per channel i: a 2-entry FIFO with occupancy cnt[i] in {0,1,2}.
  - out_valid[i] = (cnt[i] != 0).
  - out_data[i] = the oldest entry.
- in_ready is computed as follows:
  - If in_sel >= N: in_ready = 1.
  - Otherwise: in_ready = (cnt[in_sel] < 2).
  - in_ready uses registered cnt only. There is no combinational path from out_ready to in_ready.
- Accepted beat with in_sel < N: written to the tail of channel in_sel.
- Accepted beat with in_sel >= N: discarded. drop_count increments and saturates at 255 without wrapping.
- Pop: out_valid[i] & out_ready[i] removes the head. Entry 1 becomes head.
- Per-channel state transitions (push = accepted beat for i, pop = out handshake on i):
  - cnt 0: push -> 1; pop is impossible.
  - cnt 1: push only -> 2; pop only -> 0; push and pop -> 1, and the new beat becomes head.
  - cnt 2: pop -> 1; push is impossible because in_ready is low for this channel.
- Ordering: beats leave each channel in acceptance order. Channels are fully independent: a full channel never stalls beats addressed to another channel.
- Reset values:
  - All cnt = 0, so out_valid = 0.
  - out_data = 0.
  - drop_count = 0.
  - in_ready reflects in_sel combinationally. With cnt = 0 it is 1 for any in_sel.
- Reset asserted mid-operation: all buffered beats are lost immediately (asynchronous). No beat is accepted or presented on the edge where rst is high.

## Timing
- Latency: a beat accepted at edge k is visible on out_valid/out_data after edge k, i.e. in cycle k+1.
- Throughput: one beat per cycle into any channel whose consumer holds out_ready high. Sustained rate into a single channel is 1/cycle.
- The registered-occupancy rule means a channel at cnt 2 accepts again only the cycle after a pop. Alternating pushes and pops into a full channel therefore run at 1/2 rate. This is the accepted cost of keeping in_ready free of out_ready paths.
- All outputs are registered or derived from registers, except in_ready, which also depends on in_sel.

## Test plan
- Reset then route: after reset, send 0xA1 sel 0, 0xB2 sel 1, 0xC3 sel 2 on consecutive cycles with all out_ready=1.
  -> Each channel shows its beat one cycle after acceptance; out_valid pulses for 1 cycle each; drop_count=0.
- Backpressure fill: out_ready[1]=0; send 0x11, 0x22, 0x33 to sel 1.
  -> First two are accepted; in_ready=0 on the third; cnt=2.
  -> Raise out_ready[1]: pops 0x11, then 0x22; 0x33 is accepted the cycle after the first pop.
- Independence: channel 0 full with out_ready[0]=0; send a beat to sel 2.
  -> in_ready=1, beat appears on channel 2; channel 0 is unchanged.
- Push and pop at cnt 1: channel 2 holds 0x55; same cycle pop and push 0x66.
  -> Next cycle cnt=1, out_data[2]=0x66.
- Drops: send 300 beats with sel 3 (N=3).
  -> All are accepted; no out_valid rises; drop_count reaches 255 and holds.
- Reset mid-stream: with channels 0 and 1 holding data, pulse rst asynchronously between edges.
  -> out_valid=0 immediately and drop_count=0; a subsequent beat to sel 0 appears normally with 1-cycle latency.
